// File: rtl/toy_pack.sv
// Shared types and sizing constants for the toy icache.
// dataram_rd_pld_t and pc_req_t are the per-entry payloads that MSHR entries
// hand to the data-RAM read port and to the downstream linefill channel.
package toy_pack;

    localparam int MSHR_ENTRY_NUM      = 8;
    localparam int ICACHE_TXREQ_CREDIT = 4;
    localparam int ADDR_WIDTH          = 32;
    localparam int ENTRY_ID_WIDTH      = $clog2(MSHR_ENTRY_NUM);

    typedef struct packed {
        logic [ENTRY_ID_WIDTH-1:0] entry_id;
        logic [7:0]                set_idx;
        logic [1:0]                way;
    } dataram_rd_pld_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]     addr;
        logic [ENTRY_ID_WIDTH-1:0] entry_id;
    } pc_req_t;

endpackage

// File: rtl/icache_rr_arb_stage.sv
// Round-robin arbiter feeding a single registered valid/ready output stage.
// The search begins one past the previous winner so every requester is served
// in turn. credit_ok gates the grant so a caller can meter issue externally;
// tie it high when no metering is needed.
module icache_rr_arb_stage
    import toy_pack::*;
#(
    parameter int  ENTRY_NUM = MSHR_ENTRY_NUM,
    parameter type PLD_T     = dataram_rd_pld_t
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ENTRY_NUM-1:0] v_vld,
    input  PLD_T                 v_pld [ENTRY_NUM],
    output logic [ENTRY_NUM-1:0] v_rdy,
    input  logic                 credit_ok,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output PLD_T                 out_pld
);

    localparam int IDX_W = $clog2(ENTRY_NUM);

    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] win_idx;
    logic             win_found;
    logic             can_load;
    logic             grant;

    // Search for the first requester after the previous winner, wrapping around
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= ENTRY_NUM; i++) begin
            cand = IDX_W'((int'(last) + i) % ENTRY_NUM);
            if (!win_found && v_vld[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign can_load = !out_vld || out_rdy;
    assign grant    = win_found && can_load && credit_ok;

    // Grant goes back only to the winner, and only when it will actually be captured
    always_comb begin
        v_rdy = '0;
        if (grant) begin
            v_rdy[win_idx] = 1'b1;
        end
    end

    // Output register holds until handshake; pointer advances to each new winner
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld <= 1'b0;
            out_pld <= '0;
            last    <= IDX_W'(ENTRY_NUM - 1);
        end else if (grant) begin
            out_vld <= 1'b1;
            out_pld <= v_pld[win_idx];
            last    <= win_idx;
        end else if (out_rdy) begin
            out_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/icache_mshr_arb.sv
// Scheduler between the icache MSHR entries and their shared resources:
// picks the free entry for each allocation, arbitrates hit entries onto the
// data-RAM read port and miss entries onto the downstream linefill channel,
// and meters linefill issue against a downstream credit pool.
// Optional feature macro: ICACHE_MSHR_ARB_PERF_EN adds two 32-bit performance
// counters (RD grants, credit-starved TX cycles) as extra outputs.
module icache_mshr_arb
    import toy_pack::*;
#(
    parameter int ENTRY_NUM    = MSHR_ENTRY_NUM,
    parameter int TXREQ_CREDIT = ICACHE_TXREQ_CREDIT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alloc_req,
    input  logic [ENTRY_NUM-1:0]         v_alloc_vld,
    output logic                         alloc_rdy,
    output logic [ENTRY_NUM-1:0]         v_entry_en,
    output logic [$clog2(ENTRY_NUM)-1:0] alloc_idx,
    input  logic [ENTRY_NUM-1:0]         v_dataram_rd_vld,
    input  dataram_rd_pld_t              v_dataram_rd_pld [ENTRY_NUM],
    output logic [ENTRY_NUM-1:0]         v_dataram_rd_rdy,
    output logic                         dataram_rd_vld,
    input  logic                         dataram_rd_rdy,
    output dataram_rd_pld_t              dataram_rd_pld,
    input  logic [ENTRY_NUM-1:0]         v_txreq_vld,
    input  pc_req_t                      v_txreq_pld [ENTRY_NUM],
    output logic [ENTRY_NUM-1:0]         v_txreq_rdy,
    output logic                         downstream_txreq_vld,
    input  logic                         downstream_txreq_rdy,
    output pc_req_t                      downstream_txreq_pld,
    input  logic                         txreq_credit_rtn
`ifdef ICACHE_MSHR_ARB_PERF_EN
    ,
    output logic [31:0]                  perf_rd_grant_cnt,
    output logic [31:0]                  perf_tx_credit_stall_cnt
`endif
);

    localparam int IDX_W = $clog2(ENTRY_NUM);
    localparam int CW    = $clog2(TXREQ_CREDIT + 1);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(TXREQ_CREDIT);

    logic [CW-1:0] credit_cnt;
    logic          credit_ok;
    logic          tx_grant;

    assign alloc_rdy = |v_alloc_vld;

    // Lowest-index free entry wins the allocation; index is valid whenever any entry is free
    always_comb begin
        alloc_idx = '0;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (v_alloc_vld[i]) begin
                alloc_idx = IDX_W'(i);
            end
        end
    end

    // Strobe the chosen entry only for a real allocation
    always_comb begin
        v_entry_en = '0;
        if (alloc_req && alloc_rdy) begin
            v_entry_en[alloc_idx] = 1'b1;
        end
    end

    icache_rr_arb_stage #(
        .ENTRY_NUM (ENTRY_NUM),
        .PLD_T     (dataram_rd_pld_t)
    ) u_rd_arb (
        .clk       (clk),
        .rst       (rst),
        .v_vld     (v_dataram_rd_vld),
        .v_pld     (v_dataram_rd_pld),
        .v_rdy     (v_dataram_rd_rdy),
        .credit_ok (1'b1),
        .out_vld   (dataram_rd_vld),
        .out_rdy   (dataram_rd_rdy),
        .out_pld   (dataram_rd_pld)
    );

    icache_rr_arb_stage #(
        .ENTRY_NUM (ENTRY_NUM),
        .PLD_T     (pc_req_t)
    ) u_tx_arb (
        .clk       (clk),
        .rst       (rst),
        .v_vld     (v_txreq_vld),
        .v_pld     (v_txreq_pld),
        .v_rdy     (v_txreq_rdy),
        .credit_ok (credit_ok),
        .out_vld   (downstream_txreq_vld),
        .out_rdy   (downstream_txreq_rdy),
        .out_pld   (downstream_txreq_pld)
    );

    assign tx_grant  = |v_txreq_rdy;
    assign credit_ok = (credit_cnt != '0);

    // Spend a credit per linefill issued, recover one per return, saturating at the pool size
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_cnt <= CREDIT_MAX;
        end else if (tx_grant && !txreq_credit_rtn) begin
            credit_cnt <= credit_cnt - CW'(1);
        end else if (!tx_grant && txreq_credit_rtn && (credit_cnt != CREDIT_MAX)) begin
            credit_cnt <= credit_cnt + CW'(1);
        end
    end

    // A return while the pool is already full means downstream over-returned credits
    assert property (@(posedge clk) disable iff (rst)
        !(txreq_credit_rtn && !tx_grant && (credit_cnt == CREDIT_MAX)));

`ifdef ICACHE_MSHR_ARB_PERF_EN
    // Count RD grants and cycles where a loadable TX stage is starved of credits
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_rd_grant_cnt        <= '0;
            perf_tx_credit_stall_cnt <= '0;
        end else begin
            if (|v_dataram_rd_rdy) begin
                perf_rd_grant_cnt <= perf_rd_grant_cnt + 32'd1;
            end
            if ((|v_txreq_vld) && (!downstream_txreq_vld || downstream_txreq_rdy) && !credit_ok) begin
                perf_tx_credit_stall_cnt <= perf_tx_credit_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_mshr_arb.sv
// Self-checking bench for icache_mshr_arb: a queue/arithmetic reference model
// checked every cycle, plus directed scenarios with hand-computed grant orders.
`timescale 1ns/1ps
module tb_icache_mshr_arb;
    import toy_pack::*;

    localparam int N    = MSHR_ENTRY_NUM;
    localparam int CRED = ICACHE_TXREQ_CREDIT;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 alloc_req;
    logic [N-1:0]         v_alloc_vld;
    logic                 alloc_rdy;
    logic [N-1:0]         v_entry_en;
    logic [$clog2(N)-1:0] alloc_idx;
    logic [N-1:0]         v_dataram_rd_vld;
    dataram_rd_pld_t      v_dataram_rd_pld [N];
    logic [N-1:0]         v_dataram_rd_rdy;
    logic                 dataram_rd_vld;
    logic                 dataram_rd_rdy;
    dataram_rd_pld_t      dataram_rd_pld;
    logic [N-1:0]         v_txreq_vld;
    pc_req_t              v_txreq_pld [N];
    logic [N-1:0]         v_txreq_rdy;
    logic                 downstream_txreq_vld;
    logic                 downstream_txreq_rdy;
    pc_req_t              downstream_txreq_pld;
    logic                 txreq_credit_rtn;
`ifdef ICACHE_MSHR_ARB_PERF_EN
    logic [31:0]          perf_rd_grant_cnt;
    logic [31:0]          perf_tx_credit_stall_cnt;
`endif

    icache_mshr_arb dut (
        .clk                  (clk),
        .rst                  (rst),
        .alloc_req            (alloc_req),
        .v_alloc_vld          (v_alloc_vld),
        .alloc_rdy            (alloc_rdy),
        .v_entry_en           (v_entry_en),
        .alloc_idx            (alloc_idx),
        .v_dataram_rd_vld     (v_dataram_rd_vld),
        .v_dataram_rd_pld     (v_dataram_rd_pld),
        .v_dataram_rd_rdy     (v_dataram_rd_rdy),
        .dataram_rd_vld       (dataram_rd_vld),
        .dataram_rd_rdy       (dataram_rd_rdy),
        .dataram_rd_pld       (dataram_rd_pld),
        .v_txreq_vld          (v_txreq_vld),
        .v_txreq_pld          (v_txreq_pld),
        .v_txreq_rdy          (v_txreq_rdy),
        .downstream_txreq_vld (downstream_txreq_vld),
        .downstream_txreq_rdy (downstream_txreq_rdy),
        .downstream_txreq_pld (downstream_txreq_pld),
        .txreq_credit_rtn     (txreq_credit_rtn)
`ifdef ICACHE_MSHR_ARB_PERF_EN
        ,
        .perf_rd_grant_cnt        (perf_rd_grant_cnt),
        .perf_tx_credit_stall_cnt (perf_tx_credit_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit checking    = 1'b0;

    // Reference model state
    int              m_rd_last, m_tx_last, m_credits;
    bit              m_rd_vld, m_tx_vld;
    dataram_rd_pld_t m_rd_pld;
    pc_req_t         m_tx_pld;
    longint          m_perf_rd, m_perf_stall;

    // Grant indices observed on the DUT grant vectors
    int dut_rd_grants[$];
    int dut_tx_grants[$];

    // Next requester strictly after 'last', else the lowest requester overall
    function automatic int rrPick(input logic [N-1:0] vld, input int last);
        for (int e = last + 1; e < N; e++) if (vld[e]) return e;
        for (int e = 0; e <= last; e++) if (vld[e]) return e;
        return -1;
    endfunction

    function automatic int lowestSet(input logic [N-1:0] vec);
        for (int e = 0; e < N; e++) if (vec[e]) return e;
        return -1;
    endfunction

    function automatic logic [N-1:0] oneHot(input int e);
        logic [N-1:0] v;
        v = '0;
        if (e >= 0) v[e] = 1'b1;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkQueue(input string name, input int q[$], input int expq[$]);
        checkOutput({name, " count"}, 64'(q.size()), 64'(expq.size()));
        for (int i = 0; i < expq.size() && i < q.size(); i++)
            checkOutput($sformatf("%s[%0d]", name, i), 64'(q[i]), 64'(expq[i]));
    endtask

    task automatic applyStimulus(input logic areq, input logic [N-1:0] avld,
                                 input logic [N-1:0] rdvld, input logic rdrdy,
                                 input logic [N-1:0] txvld, input logic txrdy,
                                 input logic rtn);
        alloc_req            = areq;
        v_alloc_vld          = avld;
        v_dataram_rd_vld     = rdvld;
        dataram_rd_rdy       = rdrdy;
        v_txreq_vld          = txvld;
        downstream_txreq_rdy = txrdy;
        txreq_credit_rtn     = rtn;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Model advances on each rising edge from the inputs held across it
    always @(posedge clk) begin
        int rw, tw;
        bit rl, tl, rg, tg;
        if (rst) begin
            m_rd_vld = 1'b0; m_rd_pld = '0; m_rd_last = N - 1;
            m_tx_vld = 1'b0; m_tx_pld = '0; m_tx_last = N - 1;
            m_credits = CRED; m_perf_rd = 0; m_perf_stall = 0;
        end else begin
            rl = !m_rd_vld || dataram_rd_rdy;
            rw = rrPick(v_dataram_rd_vld, m_rd_last);
            rg = rl && (rw >= 0);
            tl = !m_tx_vld || downstream_txreq_rdy;
            tw = rrPick(v_txreq_vld, m_tx_last);
            tg = tl && (tw >= 0) && (m_credits > 0);
            if (rg) m_perf_rd++;
            if ((v_txreq_vld != '0) && tl && (m_credits == 0)) m_perf_stall++;
            if (rg) begin
                m_rd_vld = 1'b1; m_rd_pld = v_dataram_rd_pld[rw]; m_rd_last = rw;
            end else if (dataram_rd_rdy) begin
                m_rd_vld = 1'b0;
            end
            if (tg) begin
                m_tx_vld = 1'b1; m_tx_pld = v_txreq_pld[tw]; m_tx_last = tw;
            end else if (downstream_txreq_rdy) begin
                m_tx_vld = 1'b0;
            end
            if (tg) m_credits--;
            if (txreq_credit_rtn && m_credits < CRED) m_credits++;
        end
    end

    // Compare every DUT output against the model mid-cycle
    always @(negedge clk) begin
        int fe, rw, tw;
        if (checking) begin
            fe = lowestSet(v_alloc_vld);
            checkOutput("alloc_rdy", 64'(alloc_rdy), 64'(fe >= 0));
            checkOutput("v_entry_en", 64'(v_entry_en), 64'((alloc_req && fe >= 0) ? oneHot(fe) : '0));
            if (fe >= 0) checkOutput("alloc_idx", 64'(alloc_idx), 64'(fe));
            rw = (!m_rd_vld || dataram_rd_rdy) ? rrPick(v_dataram_rd_vld, m_rd_last) : -1;
            tw = ((!m_tx_vld || downstream_txreq_rdy) && m_credits > 0) ? rrPick(v_txreq_vld, m_tx_last) : -1;
            checkOutput("v_dataram_rd_rdy", 64'(v_dataram_rd_rdy), 64'(oneHot(rw)));
            checkOutput("v_txreq_rdy", 64'(v_txreq_rdy), 64'(oneHot(tw)));
            checkOutput("dataram_rd_vld", 64'(dataram_rd_vld), 64'(m_rd_vld));
            if (m_rd_vld) checkOutput("dataram_rd_pld", 64'(dataram_rd_pld), 64'(m_rd_pld));
            checkOutput("downstream_txreq_vld", 64'(downstream_txreq_vld), 64'(m_tx_vld));
            if (m_tx_vld) checkOutput("downstream_txreq_pld", 64'(downstream_txreq_pld), 64'(m_tx_pld));
`ifdef ICACHE_MSHR_ARB_PERF_EN
            checkOutput("perf_rd_grant_cnt", 64'(perf_rd_grant_cnt), 64'(m_perf_rd[31:0]));
            checkOutput("perf_tx_credit_stall_cnt", 64'(perf_tx_credit_stall_cnt), 64'(m_perf_stall[31:0]));
`endif
            if (v_dataram_rd_rdy != '0) dut_rd_grants.push_back(lowestSet(v_dataram_rd_rdy));
            if (v_txreq_rdy != '0) dut_tx_grants.push_back(lowestSet(v_txreq_rdy));
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int expq[$];
        for (int i = 0; i < N; i++) begin
            v_dataram_rd_pld[i].entry_id = ENTRY_ID_WIDTH'(i);
            v_dataram_rd_pld[i].set_idx  = 8'(8'h40 + i);
            v_dataram_rd_pld[i].way      = 2'(i);
            v_txreq_pld[i].addr          = 32'h8000_0000 + 32'(i * 64);
            v_txreq_pld[i].entry_id      = ENTRY_ID_WIDTH'(i);
        end
        applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        checking = 1'b1;

        // Reset state
        @(negedge clk);
        checkOutput("reset dataram_rd_vld", 64'(dataram_rd_vld), 64'd0);
        checkOutput("reset downstream_txreq_vld", 64'(downstream_txreq_vld), 64'd0);
        checkOutput("reset v_dataram_rd_rdy", 64'(v_dataram_rd_rdy), 64'd0);
        checkOutput("reset v_txreq_rdy", 64'(v_txreq_rdy), 64'd0);

        // Allocation
        tick(1);
        applyStimulus(1'b1, 8'b1010_0000, '0, 1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("alloc lit rdy", 64'(alloc_rdy), 64'd1);
        checkOutput("alloc lit en", 64'(v_entry_en), 64'h20);
        checkOutput("alloc lit idx", 64'(alloc_idx), 64'd5);
        tick(1);
        applyStimulus(1'b1, 8'b0000_0000, '0, 1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("alloc none rdy", 64'(alloc_rdy), 64'd0);
        checkOutput("alloc none en", 64'(v_entry_en), 64'd0);
        tick(1);
        applyStimulus(1'b0, 8'b0000_0110, '0, 1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("alloc noreq idx", 64'(alloc_idx), 64'd1);
        checkOutput("alloc noreq en", 64'(v_entry_en), 64'd0);

        // RD round-robin: 0, 2, 7, 0
        tick(1);
        dut_rd_grants.delete();
        applyStimulus(1'b0, '0, 8'b1000_0101, 1'b1, '0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("rd first grant", 64'(v_dataram_rd_rdy), 64'h01);
        checkOutput("rd vld before latency", 64'(dataram_rd_vld), 64'd0);
        tick(1);
        @(negedge clk);
        checkOutput("rd vld after latency", 64'(dataram_rd_vld), 64'd1);
        checkOutput("rd pld entry0", 64'(dataram_rd_pld), 64'(v_dataram_rd_pld[0]));
        tick(3);

        // Backpressure: staged entry 0 payload must hold, no grants
        applyStimulus(1'b0, '0, 8'b0000_0100, 1'b0, '0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("rd stall rdy", 64'(v_dataram_rd_rdy), 64'd0);
            checkOutput("rd stall pld", 64'(dataram_rd_pld), 64'(v_dataram_rd_pld[0]));
            tick(1);
        end
        applyStimulus(1'b0, '0, 8'b0000_0100, 1'b1, '0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("rd release grant", 64'(v_dataram_rd_rdy), 64'h04);
        tick(1);
        applyStimulus(1'b0, '0, '0, 1'b1, '0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("rd b2b vld", 64'(dataram_rd_vld), 64'd1);
        checkOutput("rd b2b pld", 64'(dataram_rd_pld), 64'(v_dataram_rd_pld[2]));
        tick(1);
        @(negedge clk);
        checkOutput("rd drain vld", 64'(dataram_rd_vld), 64'd0);
        expq = '{0, 2, 7, 0, 2};
        checkQueue("rd grant order", dut_rd_grants, expq);

        // TX credit exhaustion, then one returned credit
        tick(1);
        dut_tx_grants.delete();
        applyStimulus(1'b0, '0, '0, 1'b0, 8'hFF, 1'b1, 1'b0);
        tick(8);
        @(negedge clk);
        checkOutput("tx starved rdy", 64'(v_txreq_rdy), 64'd0);
        tick(1);
        applyStimulus(1'b0, '0, '0, 1'b0, 8'hFF, 1'b1, 1'b1);
        tick(1);
        applyStimulus(1'b0, '0, '0, 1'b0, 8'hFF, 1'b1, 1'b0);
        tick(5);
        expq = '{0, 1, 2, 3, 4};
        checkQueue("tx credit grants", dut_tx_grants, expq);

        // Grant and return in the same cycle at two credits
        applyStimulus(1'b0, '0, '0, 1'b0, 8'h00, 1'b1, 1'b1);
        tick(2);
        dut_tx_grants.delete();
        applyStimulus(1'b0, '0, '0, 1'b0, 8'hFF, 1'b1, 1'b1);
        tick(1);
        applyStimulus(1'b0, '0, '0, 1'b0, 8'hFF, 1'b1, 1'b0);
        tick(6);
        expq = '{5, 6, 7};
        checkQueue("tx same-cycle grants", dut_tx_grants, expq);

        // Reset with both channels staged
        applyStimulus(1'b0, '0, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1);
        tick(1);
        applyStimulus(1'b0, '0, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0);
        tick(1);
        @(negedge clk);
        checkOutput("pre-reset rd vld", 64'(dataram_rd_vld), 64'd1);
        checkOutput("pre-reset tx vld", 64'(downstream_txreq_vld), 64'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("mid reset rd vld", 64'(dataram_rd_vld), 64'd0);
        checkOutput("mid reset tx vld", 64'(downstream_txreq_vld), 64'd0);

        // Credits restored to the full pool by reset
        tick(1);
        dut_tx_grants.delete();
        applyStimulus(1'b0, '0, '0, 1'b0, 8'hFF, 1'b1, 1'b0);
        tick(7);
        expq = '{0, 1, 2, 3};
        checkQueue("tx after reset", dut_tx_grants, expq);

`ifdef ICACHE_MSHR_ARB_PERF_EN
        // Performance counters
        applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        applyStimulus(1'b0, '0, 8'hFF, 1'b1, '0, 1'b0, 1'b0);
        tick(10);
        applyStimulus(1'b0, '0, '0, 1'b1, '0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("perf rd lit", 64'(perf_rd_grant_cnt), 64'd10);
        tick(1);
        applyStimulus(1'b0, '0, '0, 1'b1, 8'hFF, 1'b1, 1'b0);
        tick(9);
        applyStimulus(1'b0, '0, '0, 1'b1, '0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("perf stall lit", 64'(perf_tx_credit_stall_cnt), 64'd5);
        tick(1);
        applyStimulus(1'b0, '0, 8'hFF, 1'b0, '0, 1'b1, 1'b1);
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("perf rd reset", 64'(perf_rd_grant_cnt), 64'd0);
        checkOutput("perf stall reset", 64'(perf_tx_credit_stall_cnt), 64'd0);
        checkOutput("perf reset rd vld", 64'(dataram_rd_vld), 64'd0);
        checkOutput("perf reset tx vld", 64'(downstream_txreq_vld), 64'd0);
`endif

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
